// File: rtl/seq_alu.sv
// Sequential ALU: one op per request, registered result + flags, srW strobe mirrors done.
// Optional iterative shift-and-add multiplier enabled by `SEQ_ALU_MUL_EN (else op 111 yields 0).
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             negFlag,
  output logic             isZero,
  output logic             busy,
  output logic             done,
  output logic             srW
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic [WIDTH-1:0] result_q, result_d;
  logic             neg_q, neg_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] alu_dat;
  logic [SHW-1:0]   shamt;
  logic             load_vld;
  logic [WIDTH-1:0] load_dat;

  assign shamt = b[SHW-1:0];

  always_comb begin
    alu_dat = '0;
    case (op)
      OP_ADD:  alu_dat = a + b;
      OP_SUB:  alu_dat = a - b;
      OP_AND:  alu_dat = a & b;
      OP_OR:   alu_dat = a | b;
      OP_XOR:  alu_dat = a ^ b;
      OP_SLL:  alu_dat = a << shamt;
      OP_SRA:  alu_dat = $signed(a) >>> shamt;
      default: alu_dat = '0;
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  typedef enum logic {IDLE, MUL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   count_q, count_d;
  logic [WIDTH-1:0] acc_next;

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    load_vld = 1'b0;
    load_dat = alu_dat;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            count_d  = '0;
            state_d  = MUL;
          end else begin
            load_vld = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        // Last iteration commits the sum including this cycle's partial product.
        if (count_q == SHW'(WIDTH - 1)) begin
          load_vld = 1'b1;
          load_dat = acc_next;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == MUL);
`else
  always_comb begin
    load_vld = start;
    load_dat = alu_dat;
  end

  assign busy = 1'b0;
`endif

  always_comb begin
    result_d = result_q;
    neg_d    = neg_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    if (load_vld) begin
      result_d = load_dat;
      neg_d    = load_dat[WIDTH-1];
      zero_d   = (load_dat == '0);
      done_d   = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      result_q <= '0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign result  = result_q;
  assign negFlag = neg_q;
  assign isZero  = zero_q;
  assign done    = done_q;
  assign srW     = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu; covers both SEQ_ALU_MUL_EN builds.
module tb_seq_alu;

  logic        CLK = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] result;
  logic        negFlag;
  logic        isZero;
  logic        busy;
  logic        done;
  logic        srW;

  int passed = 0;
  int total  = 0;

  seq_alu #(.WIDTH(16)) dut (
    .CLK(CLK), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .result(result), .negFlag(negFlag), .isZero(isZero),
    .busy(busy), .done(done), .srW(srW)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive one request, advance one edge, sample #1 after it.
  task automatic cyc(input logic s, input logic [2:0] o, input logic [15:0] aa, input logic [15:0] bb);
    start = s; op = o; a = aa; b = bb;
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [15:0] r, input logic n, input logic z, input logic d);
    chk({tag, ".result"}, {16'h0, result}, {16'h0, r});
    chk({tag, ".neg"},    {31'h0, negFlag}, {31'h0, n});
    chk({tag, ".zero"},   {31'h0, isZero},  {31'h0, z});
    chk({tag, ".done"},   {31'h0, done},    {31'h0, d});
    chk({tag, ".srW"},    {31'h0, srW},     {31'h0, d});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk_out("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("reset.busy", {31'h0, busy}, 32'h0);
    reset = 1'b0;

    cyc(1'b1, 3'b000, 16'h0005, 16'hFFFB);
    chk_out("add_wrap", 16'h0000, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 3'b001, 16'h1234, 16'h1111);
    chk_out("idle_hold", 16'h0000, 1'b0, 1'b1, 1'b0);

    cyc(1'b1, 3'b001, 16'h0003, 16'h0005);
    chk_out("sub_neg", 16'hFFFE, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 3'b110, 16'h8000, 16'h0004);
    chk_out("sra_neg", 16'hF800, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 3'b010, 16'hF0F0, 16'h3C3C);
    chk_out("and", 16'h3030, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 3'b011, 16'h1200, 16'h0034);
    chk_out("or", 16'h1234, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 3'b100, 16'hFFFF, 16'h7FFF);
    chk_out("xor", 16'h8000, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 3'b101, 16'h0001, 16'h0013);
    chk_out("sll_mask", 16'h0008, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 3'b110, 16'h4000, 16'h0002);
    chk_out("sra_pos", 16'h1000, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 3'b001, 16'h0000, 16'h0001);
    chk_out("sub_wrap", 16'hFFFF, 1'b1, 1'b0, 1'b1);

`ifdef SEQ_ALU_MUL_EN
    for (int i = 0; i < 16; i++) begin
      if (i == 0)      cyc(1'b1, 3'b111, 16'h0007, 16'h0009);
      else if (i == 3) cyc(1'b1, 3'b000, 16'h0001, 16'h0001);
      else             cyc(1'b0, 3'b000, 16'h0000, 16'h0000);
      chk("mul7x9.busy", {31'h0, busy}, 32'h1);
      chk("mul7x9.nodone", {31'h0, done}, 32'h0);
      chk("mul7x9.held", {16'h0, result}, 32'h0000FFFF);
    end
    cyc(1'b0, 3'b000, 16'h0000, 16'h0000);
    chk_out("mul7x9", 16'h003F, 1'b0, 1'b0, 1'b1);
    chk("mul7x9.idle", {31'h0, busy}, 32'h0);

    // New request accepted in the cycle done is high.
    cyc(1'b1, 3'b111, 16'h0100, 16'h0100);
    chk("mul_ovf.busy", {31'h0, busy}, 32'h1);
    repeat (16) cyc(1'b0, 3'b000, 16'h0000, 16'h0000);
    chk_out("mul_ovf", 16'h0000, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 3'b000, 16'h0000, 16'h0000);
    chk("mul_ovf.single", {31'h0, done}, 32'h0);

    cyc(1'b1, 3'b000, 16'h0040, 16'h0002);
    chk_out("pre_abort", 16'h0042, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 3'b111, 16'h0003, 16'h0005);
    repeat (7) cyc(1'b0, 3'b000, 16'h0000, 16'h0000);
    chk("abort.busy8", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    cyc(1'b0, 3'b000, 16'h0000, 16'h0000);
    reset = 1'b0;
    chk_out("abort", 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("abort.busy", {31'h0, busy}, 32'h0);
    begin
      int seen;
      seen = 0;
      repeat (20) begin
        cyc(1'b0, 3'b000, 16'h0000, 16'h0000);
        seen += int'(done) + int'(busy);
      end
      chk("abort.quiet", seen, 0);
    end
`else
    cyc(1'b1, 3'b111, 16'h0003, 16'h0004);
    chk_out("mul_off", 16'h0000, 1'b0, 1'b1, 1'b1);
    chk("mul_off.busy", {31'h0, busy}, 32'h0);
    cyc(1'b1, 3'b000, 16'h0040, 16'h0002);
    chk_out("pre_rst", 16'h0042, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    cyc(1'b1, 3'b001, 16'h0000, 16'h0001);
    reset = 1'b0;
    chk_out("rst_mid", 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("rst_mid.busy", {31'h0, busy}, 32'h0);
`endif

    cyc(1'b1, 3'b011, 16'h8000, 16'h0001);
    chk_out("post", 16'h8001, 1'b1, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Sequential ALU feeding the processor status register. Executes one operation per request, registers the result plus `negFlag`/`isZero`, and pulses `srW` so the status register captures the flags the same cycle the result appears. Single-cycle ops run at one per clock; multiply is an iterative shift-and-add with a busy/done handshake.

## Interface

- `WIDTH`, 16, operand/result width; must be a power of two, ≥ 4
- `CLK`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  request; sampled only when `busy`=0
- `op`  in  3  opcode, sampled with `start`
- `a`  in  WIDTH  operand A, sampled with `start`
- `b`  in  WIDTH  operand B, sampled with `start`
- `result`  out  WIDTH  registered result, held until next `done`
- `negFlag`  out  1  `result[WIDTH-1]`, registered with `result`
- `isZero`  out  1  `result`==0, registered with `result`
- `busy`  out  1  high while multiply iterates
- `done`  out  1  one-cycle pulse: `result`/flags updated this cycle
- `srW`  out  1  status-register write strobe; identical to `done`

## Operation

- Opcodes: 000 ADD a+b; 001 SUB a−b; 010 AND; 011 OR; 100 XOR; 101 SLL a by `b[log2(WIDTH)-1:0]`; 110 SRA a by `b[log2(WIDTH)-1:0]` (sign fill); 111 MUL, low WIDTH bits of a×b.
- All arithmetic modulo 2^WIDTH; carry/overflow discarded, no flag for them.
- States: IDLE, MUL. `busy` = (state==MUL).
- IDLE, `start`=1, op≠111: compute combinationally from inputs, register `result`/flags, assert `done`/`srW` next cycle; stay IDLE.
- IDLE, `start`=1, op=111: load multiplicand←a, multiplier←b, acc←0, count←0; go MUL.
- MUL, each edge: if multiplier[0], acc←acc+multiplicand; multiplicand←multiplicand<<1; multiplier←multiplier>>1; count++. At iteration WIDTH: `result`←final acc, flags updated, `done`/`srW` pulsed, return IDLE.
- `start` while `busy`=1 ignored entirely (no queueing, operands not captured).
- `start`=0 in IDLE: outputs hold, `done`=0.
- Reset values: `result`=0, `negFlag`=0, `isZero`=0, `busy`=0, `done`=0, `srW`=0, state IDLE, internal regs 0.
- Reset mid-multiply: abort next edge, no `done`, outputs to reset values.

## Timing

- Single-cycle op: `start` sampled at edge k → `done`=1 and new `result` during cycle after edge k. Throughput 1/clock; back-to-back starts give consecutive `done` pulses.
- MUL: `start` at edge k → `busy`=1 cycles k+1..k+WIDTH; `done`=1 and `result` valid after edge k+WIDTH, `busy`=0 in that cycle.
- `start` accepted in the same cycle `done` is high (state already IDLE).
- `done` never high for more than one cycle per request; `srW`==`done` always.

## Configuration

- `SEQ_ALU_MUL_EN` defined: op 111 runs the iterative multiplier as above.
- Not defined: no multiplier hardware; op 111 completes in one cycle like other ops with `result`=0, `isZero`=1, `negFlag`=0; `busy` tied 0.

## Test plan

- ADD a=0x0005, b=0xFFFB → next cycle `result`=0x0000, `isZero`=1, `negFlag`=0, `done`=`srW`=1 one cycle.
- SUB a=3, b=5 then SRA a=0x8000, b=4 on consecutive cycles → `result`=0xFFFE, `negFlag`=1, then 0xF800, `negFlag`=1; two consecutive `done` pulses.
- MUL 0x0007×0x0009 (macro defined) → `busy` high 16 cycles, then `result`=0x003F, `done`=1; `start` with ADD during busy ignored, `result` unchanged by it.
- MUL 0x0100×0x0100 → `result`=0x0000, `isZero`=1 (overflow discarded).
- `reset` asserted in 8th busy cycle of MUL → next cycle `busy`=0, `result`=0, flags 0, no `done` thereafter.
- Macro undefined: MUL 0x0003×0x0004 → one cycle later `result`=0, `isZero`=1, `busy` never asserted.
